// File: rtl/kws_requant_if.sv
// kws_requant_if: accumulator-in / packed-word-out valid/ready streams for kws_requant_seq.
interface kws_requant_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/kws_requant_seq.sv
// kws_requant_seq: per-channel rounding divide-by-POT + int8 clamp over an accumulator stream, four results per word.
// Optional saturation counter port sat_count is present when KWS_REQUANT_SAT_COUNT_EN is defined.
module kws_requant_seq #(
   parameter int unsigned NUM_CH = 64,
   parameter int unsigned CH_W   = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cfg_exp_we,
   input  logic [CH_W-1:0] cfg_exp_addr,
   input  logic [3:0]      cfg_exp_data,
   input  logic            cfg_len_we,
   input  logic [CH_W:0]   cfg_len,
   input  logic            start,
   kws_requant_if.slave    strm,
`ifdef KWS_REQUANT_SAT_COUNT_EN
   output logic [15:0]     sat_count,
`endif
   output logic            busy
);

   localparam int unsigned LEN_W = CH_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state, state_nxt;
   logic [3:0]         exp_tab [NUM_CH];
   logic [LEN_W-1:0]   len_q;
   logic [CH_W-1:0]    ch_idx;
   logic [1:0]         lane;
   logic [31:0]        pack_q;
   logic               out_valid_q;
   logic [31:0]        out_data_q;

   logic               in_ready_c;
   logic               last_pend_c;
   logic               accept_c;
   logic               emit_c;
   logic [3:0]         code_c;
   logic [3:0]         sh_c;
   logic [31:0]        mask_c;
   logic [31:0]        rem_c;
   logic [31:0]        thr_c;
   logic signed [31:0] acc_c;
   logic signed [31:0] quo_c;
   logic signed [31:0] rnd_c;
   logic [7:0]         res_byte_c;
   logic [31:0]        word_c;

   assign strm.in_ready  = in_ready_c;
   assign strm.out_valid = out_valid_q;
   assign strm.out_data  = out_data_q;
   assign busy           = (state != IDLE);

   // Rounding divide by power of two, clamp to 0..255, then re-centre to int8
   always_comb begin
      code_c     = exp_tab[ch_idx];
      sh_c       = 4'd8;
      res_byte_c = 8'h00;
      casez (code_c)
         4'b?111: sh_c = 4'd9;
         4'b??11: sh_c = 4'd5;
         4'b???1: sh_c = 4'd7;
         4'b??1?: sh_c = 4'd6;
         default: sh_c = 4'd8;
      endcase
      acc_c  = $signed(strm.in_data);
      mask_c = (32'd1 << sh_c) - 32'd1;
      rem_c  = strm.in_data & mask_c;
      thr_c  = (mask_c >> 1) + 32'(acc_c[31]);
      quo_c  = acc_c >>> sh_c;
      rnd_c  = quo_c + ((rem_c > thr_c) ? 32'sd1 : 32'sd0);
      if (rnd_c < 32'sd0) begin
         res_byte_c = 8'h80;
      end else if (rnd_c > 32'sd255) begin
         res_byte_c = 8'h7F;
      end else begin
         res_byte_c = rnd_c[7:0] ^ 8'h80;
      end
   end

   // Pack register with the current beat's byte merged into its lane
   always_comb begin
      word_c = pack_q;
      word_c[{lane, 3'b000} +: 8] = res_byte_c;
   end

   // Next state and input-side ready
   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      last_pend_c = strm.in_valid && strm.in_last;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            in_ready_c = ((lane != 2'd3) && !last_pend_c) || !out_valid_q || strm.out_ready;
            if (strm.in_valid && in_ready_c && strm.in_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (out_valid_q && strm.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept_c = strm.in_valid && in_ready_c;
   assign emit_c   = accept_c && ((lane == 2'd3) || strm.in_last);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Configuration is only writable between jobs
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) exp_tab[CH_W'(i)] <= 4'd0;
         len_q <= LEN_W'(NUM_CH);
      end else if (state == IDLE) begin
         if (cfg_exp_we) exp_tab[cfg_exp_addr] <= cfg_exp_data;
         if (cfg_len_we && (cfg_len != '0) && (cfg_len <= LEN_W'(NUM_CH))) len_q <= cfg_len;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ch_idx      <= '0;
         lane        <= 2'd0;
         pack_q      <= 32'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
      end else begin
         if ((state == IDLE) && start) begin
            ch_idx <= '0;
            lane   <= 2'd0;
            pack_q <= 32'd0;
         end
         if (accept_c) begin
            ch_idx <= ({1'b0, ch_idx} == (len_q - LEN_W'(1))) ? '0 : ch_idx + CH_W'(1);
            if (emit_c) begin
               lane   <= 2'd0;
               pack_q <= 32'd0;
            end else begin
               lane   <= lane + 2'd1;
               pack_q <= word_c;
            end
         end
         // A new word may replace the one being handshaken in the same cycle
         if (emit_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= word_c;
         end else if (strm.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

`ifdef KWS_REQUANT_SAT_COUNT_EN
   logic clamped_c;
   assign clamped_c = (rnd_c < 32'sd0) || (rnd_c > 32'sd255);

   always_ff @(posedge clk) begin
      if (reset) begin
         sat_count <= 16'd0;
      end else if ((state == IDLE) && start) begin
         sat_count <= 16'd0;
      end else if (accept_c && clamped_c && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_kws_requant_seq.sv
// tb_kws_requant_seq: directed and randomized jobs checked against an arithmetic model of the requant sequencer.
module tb_kws_requant_seq;
   localparam int NUM_CH = 64;
   localparam int CH_W   = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic            cfg_exp_we;
   logic [CH_W-1:0] cfg_exp_addr;
   logic [3:0]      cfg_exp_data;
   logic            cfg_len_we;
   logic [CH_W:0]   cfg_len;
   logic            start;
   logic            busy;
`ifdef KWS_REQUANT_SAT_COUNT_EN
   logic [15:0]     sat_count;
`endif

   kws_requant_if bus ();

   kws_requant_seq #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_exp_we   (cfg_exp_we),
      .cfg_exp_addr (cfg_exp_addr),
      .cfg_exp_data (cfg_exp_data),
      .cfg_len_we   (cfg_len_we),
      .cfg_len      (cfg_len),
      .start        (start),
      .strm         (bus),
`ifdef KWS_REQUANT_SAT_COUNT_EN
      .sat_count    (sat_count),
`endif
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model state
   logic [3:0]  m_tab [NUM_CH];
   int          m_len;
   int          m_ch;
   int          m_sat;
   bit          m_busy;
   logic [7:0]  m_bytes [$];
   logic [31:0] exp_q [$];
   bit          emit_at [int];
   logic [31:0] last_pushed;
   int          accepts = 0;
   int          words_seen = 0;

   bit rdy_force = 1'b1;
   bit rdy_val   = 1'b1;
   int rdy_pct   = 100;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Plain-integer requant: floor divide, remainder vs threshold, clamp, minus 128
   function automatic logic [7:0] ref_byte(input logic [31:0] d, input logic [3:0] code, output bit sat);
      longint x, p, q, r, thr, y;
      int s;
      if (code[2:0] == 3'b111)     s = 9;
      else if (code[1:0] == 2'b11) s = 5;
      else if (code[0])            s = 7;
      else if (code[1])            s = 6;
      else                         s = 8;
      x = longint'($signed(d));
      p = longint'(1) << s;
      q = x / p;
      if (x < 0 && q * p != x) q = q - 1;
      r   = x - q * p;
      thr = (p - 1) / 2 + ((x < 0) ? 1 : 0);
      y   = q + ((r > thr) ? 1 : 0);
      sat = (y < 0) || (y > 255);
      if (y < 0)   y = 0;
      if (y > 255) y = 255;
      return 8'(y - 128);
   endfunction

   function automatic void model_accept(input logic [31:0] d, input bit last);
      bit s;
      logic [7:0]  b;
      logic [31:0] w;
      b = ref_byte(d, m_tab[m_ch], s);
      if (s && m_sat < 65535) m_sat++;
      accepts++;
      m_bytes.push_back(b);
      m_ch = (m_ch + 1 == m_len) ? 0 : m_ch + 1;
      if (m_bytes.size() == 4 || last) begin
         w = '0;
         for (int i = 0; i < m_bytes.size(); i++) w[i*8 +: 8] = m_bytes[i];
         exp_q.push_back(w);
         last_pushed = w;
         m_bytes.delete();
         emit_at[cyc + 1] = 1'b1;
      end
   endfunction

   // Output-side ready generator
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.out_ready = rdy_force ? rdy_val : ($urandom_range(0, 99) < rdy_pct);
      end
   end

   // Compare process: latency, hold stability and word contents
   initial begin
      bit          hold_pend = 1'b0;
      logic [31:0] held = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_pend = 1'b0;
            continue;
         end
         if (emit_at.exists(cyc)) begin
            chk("emit_latency", 32'(bus.out_valid), 32'd1);
            emit_at.delete(cyc);
         end
         if (hold_pend) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", bus.out_data, held);
         end
         if (bus.out_valid && bus.out_ready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_word: got 0x%08h expected no word", bus.out_data);
            end else begin
               chk("word", bus.out_data, exp_q.pop_front());
            end
         end
         hold_pend = bus.out_valid && !bus.out_ready;
         held      = bus.out_data;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0; cfg_exp_we = 1'b0; cfg_len_we = 1'b0;
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      for (int i = 0; i < NUM_CH; i++) m_tab[i] = 4'd0;
      m_len = NUM_CH; m_ch = 0; m_sat = 0; m_busy = 1'b0;
      m_bytes.delete(); exp_q.delete(); emit_at.delete();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef KWS_REQUANT_SAT_COUNT_EN
      chk("rst_sat_count", 32'(sat_count), 32'd0);
`endif
      @(posedge clk); #1;
   endtask

   task automatic cfg_exp_w(input int addr, input logic [3:0] code);
      cfg_exp_we = 1'b1; cfg_exp_addr = CH_W'(addr); cfg_exp_data = code;
      if (!m_busy) m_tab[addr] = code;
      @(posedge clk); #1;
      cfg_exp_we = 1'b0;
   endtask

   task automatic cfg_len_w(input int v);
      cfg_len_we = 1'b1; cfg_len = (CH_W+1)'(v);
      if (!m_busy && v >= 1 && v <= NUM_CH) m_len = v;
      @(posedge clk); #1;
      cfg_len_we = 1'b0;
   endtask

   task automatic start_job();
      start = 1'b1;
      if (!m_busy) begin
         m_busy = 1'b1; m_ch = 0; m_sat = 0; m_bytes.delete();
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", 32'(busy), 32'(m_busy));
      @(posedge clk); #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input bit last, input int gap);
      int n = 0;
      bit took = 1'b0;
      bus.in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
      while (!took) begin
         @(negedge clk);
         if (bus.in_ready) begin
            took = 1'b1;
            model_accept(d, last);
         end
         @(posedge clk); #1;
         n++;
         if (!took && n > 400) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: beat 0x%08h not accepted after %0d cycles", d, n);
            break;
         end
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 2000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d words outstanding", exp_q.size());
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) break;
         n++;
         if (n > 5000) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy %0d words outstanding %0d", busy, exp_q.size());
            break;
         end
      end
      @(posedge clk); #1;
      m_busy = 1'b0;
   endtask

   function automatic logic [31:0] rand_data();
      int v;
      case ($urandom_range(0, 3))
         0: return $urandom;
         1: begin v = int'($urandom_range(0, 131071)) - 65536; return 32'(v); end
         2: return 32'($urandom_range(0, 70000));
         default: begin v = int'($urandom_range(0, 4095)) - 2048; return 32'(v); end
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0, words0, nb;
      reset = 1'b1; start = 1'b0; cfg_exp_we = 1'b0; cfg_len_we = 1'b0;
      cfg_exp_addr = '0; cfg_exp_data = '0; cfg_len = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check_reset_state();

      // Default shift 8, four beats, one full word
      cfg_len_w(4);
      start_job();
      send_beat(32'h0000_0100, 1'b0, 0);
      send_beat(32'h0000_0180, 1'b0, 0);
      send_beat(32'h0000_0000, 1'b0, 0);
      send_beat(32'h7FFF_FFFF, 1'b0, 0);
      chk("t1_model_word", last_pushed, 32'h7F80_8281);
      wait_drain();

      // Per-channel code and channel wrap
      do_reset();
      cfg_exp_w(1, 4'd1);
      cfg_len_w(2);
      start_job();
      for (int i = 0; i < 4; i++) send_beat(32'h80, i == 3, 0);
      chk("t2_model_word", last_pushed, 32'h8181_8181);
      wait_idle();

      // Negative saturating beat, partial word on in_last
      do_reset();
      start_job();
      send_beat(32'hFFFF_FF00, 1'b0, 0);
      send_beat(32'h0000_0100, 1'b1, 0);
      chk("t3_model_word", last_pushed, 32'h0000_8180);
      wait_idle();
      @(negedge clk);
      chk("t3_busy_low", 32'(busy), 32'd0);
      chk("t3_out_valid_low", 32'(bus.out_valid), 32'd0);
`ifdef KWS_REQUANT_SAT_COUNT_EN
      chk("t3_sat_count", 32'(sat_count), 32'd1);
`endif
      @(posedge clk); #1;

      // Output back-pressure with continuous input
      start_job();
      acc0 = accepts;
      words0 = words_seen;
      rdy_val = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) send_beat(32'($urandom_range(0, 65535)), i == 7, 0);
         end
         begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!bus.out_valid && n < 200);
            chk("t4_first_word_seen", 32'(bus.out_valid), 32'd1);
            repeat (5) @(negedge clk);
            chk("t4_accepts_while_stalled", 32'(accepts - acc0), 32'd7);
            chk("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            rdy_val = 1'b1;
         end
      join
      wait_idle();
      chk("t4_word_count", 32'(words_seen - words0), 32'd2);

      // Reset in the middle of a job
      start_job();
      send_beat(32'h1234_5678, 1'b0, 0);
      send_beat(32'h0000_0400, 1'b0, 0);
      do_reset();
      check_reset_state();
      start_job();
      for (int i = 0; i < 4; i++) send_beat(32'h0, i == 3, 0);
      chk("t5_model_word", last_pushed, 32'h8080_8080);
      wait_idle();

      // Config writes and start during RUN must be ignored
      do_reset();
      cfg_len_w(3);
      cfg_exp_w(0, 4'd3);
      cfg_exp_w(2, 4'd7);
      start_job();
      cfg_exp_w(0, 4'd0);
      cfg_len_w(1);
      start_job();
      send_beat(32'h20, 1'b0, 0);
      send_beat(32'h20, 1'b0, 0);
      send_beat(32'h200, 1'b0, 0);
      send_beat(32'h20, 1'b1, 0);
      chk("t6_model_word", last_pushed, 32'h8181_8081);
      wait_idle();

      // Randomized jobs
      for (int j = 0; j < 30; j++) begin
         for (int c = 0; c < 8; c++)
            if ($urandom_range(0, 1) == 1) cfg_exp_w(c, 4'($urandom_range(0, 15)));
         case ($urandom_range(0, 5))
            0: cfg_len_w(NUM_CH);
            1: cfg_len_w(int'($urandom_range(65, 127)));
            2: cfg_len_w(0);
            default: cfg_len_w(int'($urandom_range(1, 6)));
         endcase
         bus.in_valid = 1'b1; bus.in_data = $urandom;
         @(negedge clk);
         chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         rdy_pct = int'($urandom_range(30, 100));
         rdy_force = 1'b0;
         start_job();
         nb = int'($urandom_range(1, 20));
         for (int b = 0; b < nb; b++)
            send_beat(rand_data(), b == nb - 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
         wait_idle();
`ifdef KWS_REQUANT_SAT_COUNT_EN
         chk("rand_sat_count", 32'(sat_count), 32'(m_sat));
`endif
         rdy_force = 1'b1;
      end

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kws_requant_seq.md
Name: kws_requant_seq

Overview:
- Sequences the rounding-divide-by-power-of-two / int8-clamp datapath (rcdbpot) over a stream of 32-bit accumulator values.
- Supplies a per-channel exponent code from a small register table and packs four int8 results into each 32-bit output word.
- Sits between the MAC accumulator stream and the CFU output buffer.
- Both sides use valid/ready handshakes.

Parameters:
- NUM_CH, 64, depth of the per-channel exponent table (maximum channels per layer).
- CH_W, 6, width of channel index; must equal clog2(NUM_CH).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_exp_we  in  1  write strobe for exponent table
- cfg_exp_addr  in  CH_W  table entry to write
- cfg_exp_data  in  4  exponent code (bits fed to datapath exponent[3:0])
- cfg_len_we  in  1  write strobe for active channel count
- cfg_len  in  CH_W+1  active channels, legal 1..NUM_CH
- start  in  1  one-cycle pulse: begin a job
- in_valid  in  1  accumulator beat valid
- in_ready  out  1  block can accept beat
- in_data  in  32  signed accumulator
- in_last  in  1  final beat of job
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accepts word
- out_data  out  32  four int8 results, lane 0 in bits [7:0]
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset state (one cycle of reset):
  - state=IDLE, ch_idx=0, lane=0, pack register=0.
  - out_valid=0, out_data=0, in_ready=0, busy=0.
  - Every table entry=0 (shift 8), len register=NUM_CH.
  - Reset mid-job abandons all partial data.
- Config:
  - cfg_exp_we / cfg_len_we take effect the next cycle, only in IDLE; ignored while busy.
  - A cfg_len value of 0 or >NUM_CH is ignored.
- States:
  - IDLE: in_ready=0. start -> RUN with ch_idx=0, lane=0.
  - RUN: in_ready = (lane!=3 && !in_last_pending) || !out_valid || out_ready.
    - Beat accepted when in_valid && in_ready.
    - The datapath computes combinationally from in_data and table[ch_idx].
    - Result low byte is written into pack lane `lane`; lane increments mod 4.
    - ch_idx increments and wraps from len-1 to 0.
  - Word emit: when lane 3 is written, or in_last is accepted, the pack register (unwritten lanes = 0x00) moves into out_data. out_valid=1 on the following cycle (latency 1).
    - Accepting in_last -> DRAIN.
    - Otherwise stay in RUN with lane=0.
  - DRAIN: in_ready=0. Stay until the final word handshakes (out_valid && out_ready) -> IDLE, busy=0 the next cycle.
- Output handshake:
  - out_data/out_valid hold stable while out_valid && !out_ready.
  - out_valid clears after the handshake unless a new word is loaded the same cycle (back-to-back allowed: full throughput, one beat per cycle).
- Simultaneous events:
  - Lane-3 write with a pending un-acked word and out_ready=0: in_ready=0, so the beat stalls.
  - Lane-3 write with out_ready=1 the same cycle: new word replaces old, out_valid stays 1.
- start while busy: ignored.
- in_valid in IDLE: ignored, not accepted.
- Arithmetic: identical to the datapath.
  - Exponent code selects shift (x111->9, xx11->5, xxx1->7, xx1x->6, else 8).
  - Round half away in magnitude as per the remainder/threshold rule, clamp 0..255, subtract 128.
  - The block only stores bits [7:0].

Optional Feature:
- Macro KWS_REQUANT_SAT_COUNT_EN.
- When defined:
  - Adds output port sat_count [15:0].
  - Counts accepted beats whose pre-offset result clamped (to 0 or 255 before the -128).
  - Saturates at 0xFFFF; cleared by reset and by start.
- When undefined: the port and counter are absent; other behaviour is identical.

Test Plan:
- Reset, all codes 0, len=4, start; beats 0x00000100, 0x00000180, 0x00000000, 0x7FFFFFFF -> one word 0x7F808281, one cycle after the 4th accept.
- Table[1]=code 1 (shift 7), len=2, start; beats 0x80, 0x80, 0x80, 0x80 -> 0x81818181 (ch0 = 0x80>>8 rounds to 0 -> 0x80? check: remainder 128 > threshold 127 -> 1 -> 0x81); verifies ch_idx wrap and per-channel code.
- Negative beat 0xFFFFFF00 then in_last on the 2nd beat 0x100 -> word 0x00008180, then IDLE, busy=0; with SAT_COUNT_EN, sat_count=1.
- Hold out_ready=0 for 5 cycles after the first word while in_valid stays high -> in_ready drops at lane 3; out_data stable; no beats lost after release (8 beats -> exactly 2 words).
- Assert reset mid-job after 2 beats -> out_valid=0, busy=0; new start plus 4 beats of 0 -> 0x80808080.
- cfg_exp_we/cfg_len_we during RUN, and start during RUN -> no table/len change and no restart; subsequent words match pre-job config.
